mem_port_arbiter: RTL and testbench

Two-port arbiter that shares the single-port synchronous data memory between the CPU load/store path (port 0) and the program loader/debug port (port 1). It captures one request, sequences a single memory access through a three-state FSM, returns read data with a one-cycle ack pulse, and stalls the CPU while its request is pending. It sits between the `cpu` datapath's load/store signals and `data_memory`, replacing the direct connection.

---
 rtl/mem_port_arbiter.sv | 114 +++++++++++
 tb/tb_mem_port_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter sharing one synchronous data memory between the CPU
// load/store path (port 0) and the loader/debug port (port 1).
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int FIXED_PRIO = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [2:0]        funct3_0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  input  logic [2:0]        funct3_1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              cpu_stall,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [2:0]        mem_funct3,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

  localparam bit ROUND_ROBIN = (FIXED_PRIO == 0);

  state_t state;
  logic   lat_id;
  logic   lat_we;
  logic   last_grant;
  logic   pick1;

  // On a tie the round-robin mode favours whichever port did not win last.
  always_comb begin
    pick1 = req1;
    if (req0 && req1) begin
      pick1 = ROUND_ROBIN && !last_grant;
    end
  end

  assign cpu_stall = req0 & ~ack0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      lat_id     <= 1'b0;
      lat_we     <= 1'b0;
      last_grant <= 1'b1;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      rdata0     <= '0;
      rdata1     <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_funct3 <= '0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      case (state)
        // Winner's attributes are captured straight into the memory-side
        // registers, so they only reach the memory during ISSUE.
        IDLE: begin
          if (req0 || req1) begin
            lat_id     <= pick1;
            lat_we     <= pick1 ? we1 : we0;
            mem_en     <= 1'b1;
            mem_we     <= pick1 ? we1 : we0;
            mem_addr   <= pick1 ? addr1 : addr0;
            mem_wdata  <= pick1 ? wdata1 : wdata0;
            mem_funct3 <= pick1 ? funct3_1 : funct3_0;
            state      <= ISSUE;
          end
        end
        // ---- ISSUE: memory samples the access at the end of this cycle ----
        ISSUE: begin
          mem_en     <= 1'b0;
          mem_we     <= 1'b0;
          mem_addr   <= '0;
          mem_wdata  <= '0;
          mem_funct3 <= '0;
          ack0       <= !lat_id;
          ack1       <= lat_id;
          state      <= DONE;
        end
        // ---- DONE: ack is high, mem_rdata carries the read result ----
        DONE: begin
          if (!lat_we) begin
            if (lat_id) begin
              rdata1 <= mem_rdata;
            end else begin
              rdata0 <= mem_rdata;
            end
          end
          last_grant <= lat_id;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed cycle tables, hand-written corner
// sequences and a randomized run against a transaction-level model.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req0, we0, req1, we1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic [2:0]  funct3_0, funct3_1;

  logic        ack0, ack1, cpu_stall, mem_en, mem_we;
  logic [31:0] rdata0, rdata1, mem_addr, mem_wdata;
  logic [31:0] mem_rdata = 32'h0;
  logic [2:0]  mem_funct3;

  logic        ack0_b, ack1_b, cpu_stall_b, mem_en_b, mem_we_b;
  logic [31:0] rdata0_b, rdata1_b, mem_addr_b, mem_wdata_b;
  logic [31:0] mem_rdata_b = 32'h0;
  logic [2:0]  mem_funct3_b;

  always #5 clock = ~clock;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .FIXED_PRIO(0)) dut (
    .clock(clock), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .funct3_0(funct3_0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .funct3_1(funct3_1),
    .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1), .cpu_stall(cpu_stall),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_funct3(mem_funct3), .mem_rdata(mem_rdata));

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .FIXED_PRIO(1)) dut_fp (
    .clock(clock), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .funct3_0(funct3_0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .funct3_1(funct3_1),
    .ack0(ack0_b), .ack1(ack1_b), .rdata0(rdata0_b), .rdata1(rdata1_b), .cpu_stall(cpu_stall_b),
    .mem_en(mem_en_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
    .mem_funct3(mem_funct3_b), .mem_rdata(mem_rdata_b));

  // Synchronous single-port memory with a preload port for bench setup.
  logic [31:0] mem_a [256];
  logic        pre_we = 1'b0;
  logic [7:0]  pre_idx = 8'h0;
  logic [31:0] pre_val = 32'h0;
  always @(posedge clock) begin
    if (pre_we) mem_a[pre_idx] <= pre_val;
    else if (mem_en) begin
      if (mem_we) mem_a[mem_addr[9:2]] <= mem_wdata;
      else        mem_rdata <= mem_a[mem_addr[9:2]];
    end
  end

  always @(posedge clock) begin
    if (mem_en_b && !mem_we_b) mem_rdata_b <= ~mem_addr_b;
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    req0 = 1'b0; we0 = 1'b0; addr0 = 32'h0; wdata0 = 32'h0; funct3_0 = 3'h0;
    req1 = 1'b0; we1 = 1'b0; addr1 = 32'h0; wdata1 = 32'h0; funct3_1 = 3'h0;
  endtask

  task automatic preload(input logic [7:0] idx, input logic [31:0] val);
    pre_idx = idx; pre_val = val; pre_we = 1'b1;
    @(posedge clock); #1;
    pre_we = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  typedef struct {
    logic r0, w0; logic [31:0] a0;
    logic r1, w1; logic [31:0] a1, d1;
    logic e_en, e_we; logic [31:0] e_addr, e_wdata;
    logic e_ack0, e_ack1, e_stall;
    logic [31:0] e_rd0, e_rd1;
  } vec_t;
  vec_t tbl [11];

  // Transaction-level reference state for the random run.
  bit          m_free, m_port, m_we, m_last;
  int          m_start;
  logic [31:0] m_addr, m_wdata;
  logic [2:0]  m_f3;
  logic [31:0] ref_mem [16];
  logic [31:0] exp_rd [2];
  bit          pa0, pa1;

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not reach its end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tbl[0]  = '{1'b1,1'b0,32'h10, 1'b0,1'b0,32'h0,32'h0,        1'b0,1'b0,32'h0,32'h0,        1'b0,1'b0,1'b1, 32'h0,32'h0};
    tbl[1]  = '{1'b1,1'b0,32'h10, 1'b0,1'b0,32'h0,32'h0,        1'b1,1'b0,32'h10,32'h0,       1'b0,1'b0,1'b1, 32'h0,32'h0};
    tbl[2]  = '{1'b1,1'b0,32'h10, 1'b0,1'b0,32'h0,32'h0,        1'b0,1'b0,32'h0,32'h0,        1'b1,1'b0,1'b0, 32'h0,32'h0};
    tbl[3]  = '{1'b0,1'b0,32'h10, 1'b0,1'b0,32'h0,32'h0,        1'b0,1'b0,32'h0,32'h0,        1'b0,1'b0,1'b0, 32'hDEADBEEF,32'h0};
    tbl[4]  = '{1'b0,1'b0,32'h10, 1'b1,1'b1,32'h20,32'h12345678, 1'b0,1'b0,32'h0,32'h0,        1'b0,1'b0,1'b0, 32'hDEADBEEF,32'h0};
    tbl[5]  = '{1'b0,1'b0,32'h10, 1'b1,1'b1,32'h20,32'h12345678, 1'b1,1'b1,32'h20,32'h12345678, 1'b0,1'b0,1'b0, 32'hDEADBEEF,32'h0};
    tbl[6]  = '{1'b0,1'b0,32'h10, 1'b1,1'b1,32'h20,32'h12345678, 1'b0,1'b0,32'h0,32'h0,        1'b0,1'b1,1'b0, 32'hDEADBEEF,32'h0};
    tbl[7]  = '{1'b0,1'b0,32'h10, 1'b1,1'b0,32'h20,32'h0,        1'b0,1'b0,32'h0,32'h0,        1'b0,1'b0,1'b0, 32'hDEADBEEF,32'h0};
    tbl[8]  = '{1'b0,1'b0,32'h10, 1'b1,1'b0,32'h20,32'h0,        1'b1,1'b0,32'h20,32'h0,       1'b0,1'b0,1'b0, 32'hDEADBEEF,32'h0};
    tbl[9]  = '{1'b0,1'b0,32'h10, 1'b1,1'b0,32'h20,32'h0,        1'b0,1'b0,32'h0,32'h0,        1'b0,1'b1,1'b0, 32'hDEADBEEF,32'h0};
    tbl[10] = '{1'b0,1'b0,32'h10, 1'b0,1'b0,32'h0,32'h0,         1'b0,1'b0,32'h0,32'h0,        1'b0,1'b0,1'b0, 32'hDEADBEEF,32'h12345678};

    idle_inputs();
    @(posedge clock); #1;
    preload(8'd4, 32'hDEADBEEF);
    preload(8'd8, 32'h0);
    preload(8'd12, 32'h0);
    preload(8'd16, 32'h11110040);
    preload(8'd17, 32'h22220044);
    for (int k = 0; k < 16; k++) begin
      ref_mem[k] = $urandom;
      preload(8'(64 + k), ref_mem[k]);
    end

    // Reset state, with cpu_stall following req0 while reset is held.
    req0 = 1'b1;
    @(negedge clock);
    check("reset_bus", 128'({mem_en, mem_we, mem_funct3, mem_addr, mem_wdata}), 128'h0);
    check("reset_ack_stall", 128'({ack0, ack1, cpu_stall}), 128'b001);
    check("reset_rdata", 128'({rdata0, rdata1}), 128'h0);
    req0 = 1'b0;
    #1;
    check("reset_stall_low", 128'(cpu_stall), 128'h0);
    @(posedge clock); #1;
    reset = 1'b0;

    // Directed table: port 0 read, then port 1 write and read-back.
    for (int i = 0; i < 11; i++) begin
      req0 = tbl[i].r0; we0 = tbl[i].w0; addr0 = tbl[i].a0;
      req1 = tbl[i].r1; we1 = tbl[i].w1; addr1 = tbl[i].a1; wdata1 = tbl[i].d1;
      @(negedge clock);
      check($sformatf("tbl%0d_bus", i), 128'({mem_en, mem_we, mem_addr, mem_wdata}),
            128'({tbl[i].e_en, tbl[i].e_we, tbl[i].e_addr, tbl[i].e_wdata}));
      check($sformatf("tbl%0d_ack", i), 128'({ack0, ack1, cpu_stall}),
            128'({tbl[i].e_ack0, tbl[i].e_ack1, tbl[i].e_stall}));
      check($sformatf("tbl%0d_rdata", i), 128'({rdata0, rdata1}),
            128'({tbl[i].e_rd0, tbl[i].e_rd1}));
      @(posedge clock); #1;
    end

    // Both ports held: round-robin alternates, fixed priority starves port 1.
    do_reset();
    req0 = 1'b1; addr0 = 32'h10; req1 = 1'b1; addr1 = 32'h20;
    for (int c = 0; c < 15; c++) begin
      if (c == 12) req0 = 1'b0;
      @(negedge clock);
      if (c < 12) begin
        check($sformatf("rr_c%0d", c), 128'({ack0, ack1, cpu_stall}),
              128'({(c == 2 || c == 8), (c == 5 || c == 11), !(c == 2 || c == 8)}));
        check($sformatf("fp_c%0d", c), 128'({ack0_b, ack1_b}), 128'({(c % 3 == 2), 1'b0}));
      end else begin
        check($sformatf("fp_drop_c%0d", c), 128'({ack0_b, ack1_b}), 128'({1'b0, (c == 14)}));
      end
      @(posedge clock); #1;
    end

    // Reset lands during ISSUE of a port-0 write: nothing written, no ack.
    do_reset();
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'h30; wdata0 = 32'hCAFEF00D;
    @(posedge clock); #1;
    check("mid_issue_en", 128'({mem_en, mem_we, mem_addr}), 128'({1'b1, 1'b1, 32'h30}));
    reset = 1'b1; req0 = 1'b0;
    #1;
    check("mid_reset_bus", 128'({mem_en, mem_we, mem_funct3, mem_addr, mem_wdata}), 128'h0);
    check("mid_reset_ack", 128'({ack0, ack1, cpu_stall}), 128'h0);
    @(posedge clock); #1;
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      check($sformatf("mid_after_c%0d", c), 128'({ack0, ack1, mem_en}), 128'h0);
      @(posedge clock); #1;
    end
    check("mid_mem_untouched", 128'(mem_a[12]), 128'h0);

    // Attribute change after latch is ignored.
    do_reset();
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h40;
    @(posedge clock); #1;
    addr0 = 32'h44;
    @(negedge clock);
    check("latch_addr", 128'({mem_en, mem_addr}), 128'({1'b1, 32'h40}));
    @(posedge clock); #1;
    @(negedge clock);
    check("latch_ack", 128'({ack0, ack1}), 128'b10);
    @(posedge clock); #1;
    req0 = 1'b0;
    @(negedge clock);
    check("latch_rdata", 128'(rdata0), 128'h11110040);
    @(posedge clock); #1;

    // Randomized run against the transaction-level model.
    do_reset();
    m_free = 1'b1; m_last = 1'b1; m_start = 0; m_port = 1'b0; m_we = 1'b0;
    m_addr = 32'h0; m_wdata = 32'h0; m_f3 = 3'h0;
    exp_rd[0] = 32'h0; exp_rd[1] = 32'h0; pa0 = 1'b0; pa1 = 1'b0;
    for (int c = 0; c < 400; c++) begin
      bit ea0, ea1, een;
      if (!req0 || pa0) begin
        if ($urandom_range(0, 2) != 0) begin
          req0 = 1'b1; we0 = 1'($urandom_range(0, 1));
          addr0 = 32'h100 + 32'($urandom_range(0, 15)) * 4;
          wdata0 = $urandom; funct3_0 = 3'($urandom_range(0, 7));
        end else req0 = 1'b0;
      end
      if (!req1 || pa1) begin
        if ($urandom_range(0, 2) != 0) begin
          req1 = 1'b1; we1 = 1'($urandom_range(0, 1));
          addr1 = 32'h100 + 32'($urandom_range(0, 15)) * 4;
          wdata1 = $urandom; funct3_1 = 3'($urandom_range(0, 7));
        end else req1 = 1'b0;
      end
      @(negedge clock);
      een = !m_free && (c == m_start + 1);
      ea0 = !m_free && (c == m_start + 2) && !m_port;
      ea1 = !m_free && (c == m_start + 2) && m_port;
      check($sformatf("rnd%0d_bus", c), 128'({mem_en, mem_we, mem_funct3, mem_addr, mem_wdata}),
            een ? 128'({1'b1, m_we, m_f3, m_addr, m_wdata}) : 128'h0);
      check($sformatf("rnd%0d_ack", c), 128'({ack0, ack1, cpu_stall}), 128'({ea0, ea1, req0 & ~ea0}));
      check($sformatf("rnd%0d_rdata", c), 128'({rdata0, rdata1}), 128'({exp_rd[0], exp_rd[1]}));
      if (m_free) begin
        if (req0 || req1) begin
          m_port  = (req0 && req1) ? !m_last : req1;
          m_we    = m_port ? we1 : we0;
          m_addr  = m_port ? addr1 : addr0;
          m_wdata = m_port ? wdata1 : wdata0;
          m_f3    = m_port ? funct3_1 : funct3_0;
          m_start = c;
          m_free  = 1'b0;
        end
      end else if (c == m_start + 2) begin
        if (m_we) ref_mem[m_addr[5:2]] = m_wdata;
        else      exp_rd[m_port] = ref_mem[m_addr[5:2]];
        m_last = m_port;
        m_free = 1'b1;
      end
      pa0 = ea0; pa1 = ea1;
      @(posedge clock); #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
